// File: rtl/pcm_rom_arbiter_pkg.sv
// Shared definitions for the PCM ROM arbiter: FSM states, port IDs and the
// default VROMB address offset.
package pcm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } pcm_state_e;

  localparam logic PORT_RA = 1'b0;
  localparam logic PORT_PA = 1'b1;

  localparam logic [23:0] VROMB_BASE_DEFAULT = 24'h200000;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pcm_rom_arbiter_if.sv
// Bundle of the request/ack ports, the ROM bus and the status outputs.
//
// Handshake: a requester raises REQ (level) with ADDR stable and keeps it up
// until the arbiter leaves IDLE (BUSY rises). The arbiter answers with a
// single-cycle ACK, and DATA is valid from that cycle until the next ACK of
// the same port. A REQ still high when the arbiter is back in IDLE is taken
// as a fresh request, so holding REQ streams back-to-back accesses.
interface pcm_rom_arbiter_if;
  import pcm_arb_pkg::*;

  logic        MODE;
  logic        RA_REQ;
  logic [23:0] RA_ADDR;
  logic        RA_ACK;
  logic [7:0]  RA_DATA;
  logic        PA_REQ;
  logic [23:0] PA_ADDR;
  logic        PA_ACK;
  logic [7:0]  PA_DATA;
  logic [23:0] ROM_A;
  logic        ROM_nOE;
  logic [7:0]  ROM_D;
  logic        GRANT;
  logic        BUSY;
  pcm_state_e  DBG_STATE;

  modport slave (
    input  MODE, RA_REQ, RA_ADDR, PA_REQ, PA_ADDR, ROM_D,
    output RA_ACK, RA_DATA, PA_ACK, PA_DATA, ROM_A, ROM_nOE, GRANT, BUSY,
           DBG_STATE
  );

  modport master (
    output MODE, RA_REQ, RA_ADDR, PA_REQ, PA_ADDR, ROM_D,
    input  RA_ACK, RA_DATA, PA_ACK, PA_DATA, ROM_A, ROM_nOE, GRANT, BUSY,
           DBG_STATE
  );

endinterface

// File: rtl/pcm_rom_arbiter_rr_arb.sv
// Two-way round-robin arbiter: with both requests pending, the port that
// did not win last time is chosen.
module pcm_rr_arb
  import pcm_arb_pkg::*;
(
  input  logic req_ra_i,
  input  logic req_pa_i,
  input  logic last_gnt_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  // Pick a winner from the current requests and the last grant
  always_comb begin
    gnt_valid_o = req_ra_i | req_pa_i;
    gnt_id_o    = PORT_RA;
    if (req_ra_i && req_pa_i) begin
      gnt_id_o = ~last_gnt_i;
    end else if (req_pa_i) begin
      gnt_id_o = PORT_PA;
    end
  end

endmodule

// File: rtl/pcm_rom_arbiter.sv
// Arbitrates ADPCM-A and ADPCM-B sample reads onto a single ROM bus. One
// access is in flight at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles with
// ROM_nOE low) -> RECOVER (one cycle) -> IDLE.
module pcm_rom_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [23:0] VROMB_BASE  = VROMB_BASE_DEFAULT
) (
  input  logic               CLK_68KCLKB,
  input  logic               RESET,
  pcm_rom_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  pcm_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [23:0]      rom_a_q;
  logic [23:0]      rom_a_d;
  logic             rom_noe_q;
  logic             grant_q;
  logic             ra_ack_q;
  logic             pa_ack_q;
  logic [7:0]       ra_data_q;
  logic [7:0]       pa_data_q;
  logic             gnt_valid;
  logic             gnt_id;

  pcm_rr_arb u_rr_arb (
    .req_ra_i    (bus.RA_REQ),
    .req_pa_i    (bus.PA_REQ),
    .last_gnt_i  (grant_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // ROM address for the winning port; VROMB offset only for PA in split mode
  always_comb begin
    rom_a_d = bus.RA_ADDR;
    if (gnt_id == PORT_PA) begin
      rom_a_d = bus.MODE ? (bus.PA_ADDR | VROMB_BASE) : bus.PA_ADDR;
    end
  end

  // Access sequencer with registered ROM controls, ACK pulses and data
  always_ff @(posedge CLK_68KCLKB or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rom_a_q   <= '0;
      rom_noe_q <= 1'b1;
      grant_q   <= PORT_PA;
      ra_ack_q  <= 1'b0;
      pa_ack_q  <= 1'b0;
      ra_data_q <= '0;
      pa_data_q <= '0;
    end else begin
      ra_ack_q <= 1'b0;
      pa_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rom_noe_q <= 1'b1;
          if (gnt_valid) begin
            rom_a_q   <= rom_a_d;
            rom_noe_q <= 1'b0;
            cnt_q     <= WAIT_CNT;
            grant_q   <= gnt_id;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (grant_q == PORT_RA) begin
              ra_data_q <= bus.ROM_D;
              ra_ack_q  <= 1'b1;
            end else begin
              pa_data_q <= bus.ROM_D;
              pa_ack_q  <= 1'b1;
            end
            rom_noe_q <= 1'b1;
            state_q   <= ST_RECOVER;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RECOVER: begin
          rom_noe_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          rom_noe_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ROM_A     = rom_a_q;
  assign bus.ROM_nOE   = rom_noe_q;
  assign bus.GRANT     = grant_q;
  assign bus.RA_ACK    = ra_ack_q;
  assign bus.PA_ACK    = pa_ack_q;
  assign bus.RA_DATA   = ra_data_q;
  assign bus.PA_DATA   = pa_data_q;
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// Testbench for pcm_rom_arbiter: a WAIT_CYCLES=2 instance checked through an
// expected-response queue, plus a WAIT_CYCLES=0 instance for the
// minimum-latency case.
module tb_pcm_rom_arbiter;
  import pcm_arb_pkg::*;

  localparam int W2 = 2;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected entry: {port, rom_a[23:0], data[7:0]}
  logic [32:0] exp_q[$];

  pcm_rom_arbiter_if bus2 ();
  pcm_rom_arbiter_if bus0 ();

  pcm_rom_arbiter #(.WAIT_CYCLES(W2)) dut2 (
    .CLK_68KCLKB (clk),
    .RESET       (rst),
    .bus         (bus2)
  );

  pcm_rom_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .CLK_68KCLKB (clk),
    .RESET       (rst),
    .bus         (bus0)
  );

  // ROM contents: fixed byte at 0x012345, otherwise an XOR of the address
  function automatic logic [7:0] rom_model(input logic [23:0] a);
    if (a == 24'h012345) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  assign bus2.ROM_D = rom_model(bus2.ROM_A);
  assign bus0.ROM_D = rom_model(bus0.ROM_A);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [7:0] mdl_ra;
  logic [7:0] mdl_pa;
  int         noe_lo;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      mdl_ra = '0;
      mdl_pa = '0;
      noe_lo = 0;
    end else begin
      if (!bus2.ROM_nOE) noe_lo++;
      if (bus2.RA_ACK || bus2.PA_ACK) begin
        chk("ack_overlap", {63'd0, bus2.RA_ACK & bus2.PA_ACK}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {63'd0, bus2.PA_ACK}, {63'd0, e[32]});
          chk("grant", {63'd0, bus2.GRANT}, {63'd0, e[32]});
          chk("rom_a_at_ack", {40'd0, bus2.ROM_A}, {40'd0, e[31:8]});
          if (e[32]) mdl_pa = e[7:0];
          else       mdl_ra = e[7:0];
          chk("ra_data", {56'd0, bus2.RA_DATA}, {56'd0, mdl_ra});
          chk("pa_data", {56'd0, bus2.PA_DATA}, {56'd0, mdl_pa});
          chk("noe_low_cycles", 64'(noe_lo), 64'(W2 + 1));
        end
        noe_lo = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request on dut2 from a negedge with the FSM in IDLE.
  task automatic do_req(input logic port, input logic [23:0] addr, input logic mode,
                        input logic [23:0] exp_a, input logic [7:0] exp_d,
                        input bit chg_addr);
    int n;
    bit got;
    exp_q.push_back({port, exp_a, exp_d});
    bus2.MODE = mode;
    if (port == PORT_RA) begin
      bus2.RA_ADDR = addr;
      bus2.RA_REQ  = 1'b1;
    end else begin
      bus2.PA_ADDR = addr;
      bus2.PA_REQ  = 1'b1;
    end
    n   = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        bus2.RA_REQ = 1'b0;
        bus2.PA_REQ = 1'b0;
      end
      if (chg_addr && n == 2) bus2.RA_ADDR = 24'hFFFFFF;
      if (chg_addr && n == 3) chk("rom_a_hold_access", {40'd0, bus2.ROM_A}, {40'd0, exp_a});
      if (bus2.RA_ACK || bus2.PA_ACK) got = 1;
    end
    chk("ack_latency", got ? 64'(n) : 64'd999, 64'(W2 + 2));
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", {63'd0, bus2.BUSY}, 64'd0);
    chk("idle_noe", {63'd0, bus2.ROM_nOE}, 64'd1);
    chk("rom_a_hold_idle", {40'd0, bus2.ROM_A}, {40'd0, exp_a});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int acks;
    int lo;
    bit got;

    rst = 1'b1;
    bus2.MODE = 1'b0; bus2.RA_REQ = 1'b0; bus2.PA_REQ = 1'b0;
    bus2.RA_ADDR = '0; bus2.PA_ADDR = '0;
    bus0.MODE = 1'b0; bus0.RA_REQ = 1'b0; bus0.PA_REQ = 1'b0;
    bus0.RA_ADDR = '0; bus0.PA_ADDR = '0;

    // Reset values
    @(negedge clk);
    chk("rst_state", {62'd0, bus2.DBG_STATE}, {62'd0, ST_IDLE});
    chk("rst_noe", {63'd0, bus2.ROM_nOE}, 64'd1);
    chk("rst_rom_a", {40'd0, bus2.ROM_A}, 64'd0);
    chk("rst_acks", {62'd0, bus2.RA_ACK, bus2.PA_ACK}, 64'd0);
    chk("rst_data", {48'd0, bus2.RA_DATA, bus2.PA_DATA}, 64'd0);
    chk("rst_grant", {63'd0, bus2.GRANT}, 64'd1);
    chk("rst_busy", {63'd0, bus2.BUSY}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic RA read
    do_req(PORT_RA, 24'h012345, 1'b0, 24'h012345, 8'hA5, 1'b0);
    // PA in split mode gets the VROMB offset, shared mode does not
    do_req(PORT_PA, 24'h000100, 1'b1, 24'h200100, 8'h1D, 1'b0);
    do_req(PORT_PA, 24'h000100, 1'b0, 24'h000100, 8'h3D, 1'b0);
    // Address change mid-access is ignored, used on the next grant
    do_req(PORT_RA, 24'h000010, 1'b0, 24'h000010, 8'h2C, 1'b1);
    do_req(PORT_RA, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 8'hC3, 1'b0);

    // Reset in the middle of an access
    bus2.MODE = 1'b0;
    bus2.RA_ADDR = 24'h000040;
    bus2.RA_REQ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", {63'd0, bus2.BUSY}, 64'd1);
    chk("abort_noe_pre", {63'd0, bus2.ROM_nOE}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_noe", {63'd0, bus2.ROM_nOE}, 64'd1);
    chk("abort_ack", {62'd0, bus2.RA_ACK, bus2.PA_ACK}, 64'd0);
    chk("abort_data", {48'd0, bus2.RA_DATA, bus2.PA_DATA}, 64'd0);
    chk("abort_busy", {63'd0, bus2.BUSY}, 64'd0);
    chk("abort_rom_a", {40'd0, bus2.ROM_A}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(PORT_RA, 24'h000040, 1'b0, 24'h000040, 8'h7C, 1'b0);

    // Both ports streaming after reset: RA, PA, RA, PA
    apply_reset();
    @(negedge clk);
    exp_q.push_back({PORT_RA, 24'h000020, 8'h1C});
    exp_q.push_back({PORT_PA, 24'h000030, 8'h0C});
    exp_q.push_back({PORT_RA, 24'h000020, 8'h1C});
    exp_q.push_back({PORT_PA, 24'h000030, 8'h0C});
    bus2.MODE = 1'b0;
    bus2.RA_ADDR = 24'h000020;
    bus2.PA_ADDR = 24'h000030;
    bus2.RA_REQ = 1'b1;
    bus2.PA_REQ = 1'b1;
    acks = 0;
    n = 0;
    while (acks < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus2.RA_ACK || bus2.PA_ACK) acks++;
    end
    bus2.RA_REQ = 1'b0;
    bus2.PA_REQ = 1'b0;
    chk("stream_acks", 64'(acks), 64'd4);
    repeat (6) @(negedge clk);
    chk("stream_idle", {63'd0, bus2.BUSY}, 64'd0);

    // Zero wait states on the second instance
    bus0.RA_ADDR = 24'h000050;
    bus0.RA_REQ = 1'b1;
    n = 0;
    lo = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) bus0.RA_REQ = 1'b0;
      if (!bus0.ROM_nOE) lo++;
      if (bus0.RA_ACK) got = 1;
      if (bus0.PA_ACK) chk("w0_pa_ack", 64'd1, 64'd0);
    end
    chk("w0_latency", got ? 64'(n) : 64'd999, 64'd2);
    chk("w0_noe_low", 64'(lo), 64'd1);
    chk("w0_data", {56'd0, bus0.RA_DATA}, 64'h6C);
    chk("w0_rom_a", {40'd0, bus0.ROM_A}, 64'h000050);
    repeat (2) @(negedge clk);
    chk("w0_idle", {62'd0, bus0.DBG_STATE}, {62'd0, ST_IDLE});

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
